// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation select encoding.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/usr_shift_counter.sv
// Counts shift edges modulo WIDTH and emits a registered one-cycle DONE pulse on wrap.
module usr_shift_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic shift,
    input  logic clear,
    output logic DONE
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    // Clear wins over shift; a wrap resets the count instead of reaching WIDTH
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (shift) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign DONE = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift-left / shift-right / parallel load with DONE every WIDTH shifts.
// Optional rotate input ROT is present when USR_ROTATE_EN is defined.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_L,
    input  logic             SI_R,
`ifdef USR_ROTATE_EN
    input  logic             ROT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] NotQ,
    output logic             SO_L,
    output logic             SO_R,
    output logic             DONE
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             in_l;
    logic             in_r;
    logic             shift;
    logic             clear;
    mode_t            mode;

    assign mode = mode_t'(MODE);

    // Bits entering on each shift direction: serial inputs, or the wrapped-out bit when rotating
`ifdef USR_ROTATE_EN
    assign in_l = ROT ? q_q[WIDTH-1] : SI_L;
    assign in_r = ROT ? q_q[0]       : SI_R;
`else
    assign in_l = SI_L;
    assign in_r = SI_R;
`endif

    always_comb begin
        q_d   = q_q;
        shift = 1'b0;
        clear = 1'b0;
        case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHL: begin
                q_d   = {q_q[WIDTH-2:0], in_l};
                shift = 1'b1;
            end
            MODE_SHR: begin
                q_d   = {in_r, q_q[WIDTH-1:1]};
                shift = 1'b1;
            end
            MODE_LOAD: begin
                q_d   = D;
                clear = 1'b1;
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .shift (shift),
        .clear (clear),
        .DONE  (DONE)
    );

    assign Q    = q_q;
    assign NotQ = ~q_q;
    assign SO_L = q_q[WIDTH-1];
    assign SO_R = q_q[0];

endmodule
